ps2_scancode_fifo: RTL
======================

Name: ps2_scancode_fifo

Overview:
Sits directly downstream of ps2_decoder. It consumes raw PS/2 set-2 bytes and folds the E0 (extended) and F0 (break) prefixes into single key events. Events are buffered in a first-word-fall-through FIFO so the 68k host can read them at its own pace. It raises a sticky interrupt when an event is queued and flags overflow when an event is lost.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
AW, 3, address width; must equal log2(DEPTH).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_data  input  8  scan byte from ps2_decoder data
in_valid  input  1  ps2_decoder valid; level signal, new byte on each rising edge
rd_en  input  1  host pop strobe; one pop per cycle while high and not empty
irq_clear  input  1  clears irq and overflow
rd_code  output  8  head entry scan code (FWFT)
rd_ext  output  1  head entry had E0 prefix
rd_brk  output  1  head entry had F0 prefix (key release)
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  AW+1  entries held, 0..DEPTH
irq  output  1  sticky event-pending interrupt
overflow  output  1  sticky, an event was dropped

Behaviour:
- Reset (async, active-high): FIFO pointers=0, count=0, empty=1, full=0, irq=0, overflow=0, prefix flags cleared, in_valid edge register=0. rd_code/rd_ext/rd_brk=0 while empty.
- Byte strobe: stb = in_valid & ~in_valid_q. A level held high yields exactly one stb.
- Prefix state (flags ext_f, brk_f):
  - stb with in_data=8'hE0: ext_f<=1; no push.
  - stb with in_data=8'hF0: brk_f<=1; no push.
  - stb with any other byte: push event {ext_f,brk_f,in_data}, then clear both flags in the same cycle.
  - Repeated prefixes are idempotent: E0 E0 12 gives ext=1, brk=0. Order is irrelevant: E0 F0 x and F0 E0 x both give ext=1, brk=1.
  - 8'hE1, 8'hAA, 8'hFA and 8'hFE are ordinary codes and are pushed as-is.
- Push timing: the event becomes visible on rd_* and count the cycle after stb (1-cycle latency).
- FIFO: 10-bit entries. Head is presented combinationally from memory[rd_ptr]. Pointers are AW bits wide and wrap modulo DEPTH.
- Pop: rd_en & ~empty advances rd_ptr at the clock edge. rd_en while empty is ignored; no underflow, state unchanged.
- Push while full with no pop: event dropped, overflow<=1, FIFO unchanged, prefix flags still cleared.
- Push and pop in the same cycle:
  - Not empty: both happen and count is unchanged. This includes the full case, where nothing is dropped and overflow is not set.
  - Empty: push happens, pop is ignored, count becomes 1.
- full = (count==DEPTH); empty = (count==0).
- irq: set on every accepted push. Cleared by irq_clear. If a push and irq_clear land in the same cycle, set wins. irq stays set after the FIFO drains until cleared.
- overflow: cleared by irq_clear. If a drop and irq_clear land in the same cycle, set wins.
- Reset mid-operation: all queued events, partial prefixes and sticky flags are discarded immediately.
- No prefix timeout: a dangling E0/F0 persists until the next non-prefix byte or reset.

Test Plan:
- Reset, then stb 8'h1C -> next cycle empty=0, count=1, rd_code=8'h1C, rd_ext=0, rd_brk=0, irq=1.
- Stb sequence E0 F0 74, then pop -> single entry: rd_code=8'h74, ext=1, brk=1; count 1->0 after rd_en; irq stays 1 until irq_clear.
- Hold in_valid high 20 cycles with 8'h29 -> exactly one entry pushed (count=1).
- Push 9 distinct codes 8'h01..8'h09 into DEPTH=8 -> count=8, full=1, overflow=1; pop order 01..08; 09 absent.
- At full, pulse rd_en in the same cycle as stb 8'h55 -> count stays 8, overflow=0; the last entry read is 8'h55.
- stb 8'h12 and irq_clear in the same cycle; then irq_clear alone -> irq=1 after the first cycle, irq=0 after the second. Also assert reset mid-sequence after stb E0 -> empty=1 and irq=0, and the next stb 8'h12 gives ext=0.

Source files
------------

// File: rtl/ps2_scancode_fifo_if.sv
// Host-facing bundle of ps2_scancode_fifo: decoder byte input, host pop/clear, FWFT head and status.
interface ps2_scancode_fifo_if #(
    parameter int unsigned AW = 3
);
    logic [7:0]  in_data;
    logic        in_valid;
    logic        rd_en;
    logic        irq_clear;
    logic [7:0]  rd_code;
    logic        rd_ext;
    logic        rd_brk;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        irq;
    logic        overflow;

    // Driver side: decoder plus 68k host.
    modport master (
        output in_data, in_valid, rd_en, irq_clear,
        input  rd_code, rd_ext, rd_brk, empty, full, count, irq, overflow
    );

    // The FIFO itself.
    modport slave (
        input  in_data, in_valid, rd_en, irq_clear,
        output rd_code, rd_ext, rd_brk, empty, full, count, irq, overflow
    );
endinterface

// File: rtl/ps2_scancode_fifo.sv
// Folds PS/2 set-2 E0/F0 prefixes into {ext,brk,code} events and buffers them
// in a first-word-fall-through FIFO with sticky irq and overflow flags.
module ps2_scancode_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_scancode_fifo_if.slave   bus
);
    localparam int unsigned EW = 10;
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]  CODE_EXT = 8'hE0;
    localparam logic [7:0]  CODE_BRK = 8'hF0;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_valid_q;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          irq_q, irq_d;
    logic          overflow_q, overflow_d;

    logic          stb_c;
    logic          push_req_c;
    logic          push_ok_c;
    logic          drop_c;
    logic          pop_c;
    logic          empty_c;
    logic          full_c;
    logic [EW-1:0] entry_c;
    logic [EW-1:0] head_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == COUNT_FULL);
    assign head_c  = mem_q[rd_ptr_q];
    assign entry_c = {ext_q, brk_q, bus.in_data};

    // Byte strobe, push/pop qualification and next-state for all state registers.
    always_comb begin
        stb_c      = bus.in_valid & ~in_valid_q;
        push_req_c = 1'b0;
        push_ok_c  = 1'b0;
        drop_c     = 1'b0;
        pop_c      = bus.rd_en & ~empty_c;
        ext_d      = ext_q;
        brk_d      = brk_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        irq_d      = irq_q;
        overflow_d = overflow_q;

        if (stb_c) begin
            if (bus.in_data == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (bus.in_data == CODE_BRK) begin
                brk_d = 1'b1;
            end else begin
                push_req_c = 1'b1;
                ext_d      = 1'b0;
                brk_d      = 1'b0;
            end
        end

        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        push_ok_c = push_req_c & (~full_c | pop_c);
        drop_c    = push_req_c & full_c & ~pop_c;

        if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)     rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set beats clear when both land in the same cycle.
        if (bus.irq_clear) begin
            irq_d      = 1'b0;
            overflow_d = 1'b0;
        end
        if (push_ok_c) irq_d      = 1'b1;
        if (drop_c)    overflow_d = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_valid_q <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            irq_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_valid_q <= bus.in_valid;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            irq_q      <= irq_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are only observed through the empty gate below.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= entry_c;
    end

    // Head presented straight from storage, forced to zero while empty.
    assign bus.rd_code  = empty_c ? 8'h00 : head_c[7:0];
    assign bus.rd_brk   = empty_c ? 1'b0  : head_c[8];
    assign bus.rd_ext   = empty_c ? 1'b0  : head_c[9];
    assign bus.empty    = empty_c;
    assign bus.full     = full_c;
    assign bus.count    = count_q;
    assign bus.irq      = irq_q;
    assign bus.overflow = overflow_q;
endmodule
